alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Command-issue and result-capture controller for the 16-bit function-style ALU. It buffers operation requests in a small FIFO and drives one request at a time onto the ALU's combinational `opcode`/`input1`/`input2`/`shiftValue` port. It samples `result`/`carryFlag` one cycle later and returns them on a valid/ready response channel. It sits between the ALU and any upstream requester or test sequencer, and owns all timing around the purely combinational ALU.

## Interface
- `WIDTH`, 16: operand/result width.
- `SHW`, 5: shift-amount width.
- `DEPTH`, 4: command FIFO depth; must be a power of two, ≥2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_opcode` in 4: ALU opcode.
- `cmd_a` in WIDTH: first operand.
- `cmd_b` in WIDTH: second operand.
- `cmd_shift` in SHW: shift amount.
- `alu_opcode` out 4: drives ALU `opcode`.
- `alu_input1` out WIDTH: drives ALU `input1`.
- `alu_input2` out WIDTH: drives ALU `input2`.
- `alu_shift` out SHW: drives ALU `shiftValue`.
- `alu_result` in WIDTH: from ALU `result`.
- `alu_carry` in 1: from ALU `carryFlag`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_result` out WIDTH: captured result.
- `rsp_carry` out 1: captured carry.
- `rsp_opcode` out 4: opcode of the responding command.
- `rsp_err` out 1: illegal opcode; driven 0 unless the opcode check is compiled in.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.

## Operation
- Command accept: on a clock edge where `cmd_valid && cmd_ready`, the command is pushed. `cmd_ready = !full`; there is no pass-through when full, even if a pop happens in the same cycle.
- FIFO behaviour:
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle are legal and leave the count unchanged.
- FSM states: IDLE, DRIVE, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the operand registers and go to DRIVE. Otherwise stay in IDLE.
- DRIVE: the operand registers drive the `alu_*` outputs. At the end of the cycle:
  - capture `alu_result`, `alu_carry` and the opcode into the response registers;
  - set `rsp_valid` = 1;
  - go to RESP.
- RESP: hold the response, stable, until `rsp_valid && rsp_ready`. On the handshake:
  - if the FIFO is non-empty, pop the next command and go to DRIVE;
  - otherwise clear `rsp_valid` and go to IDLE.
- `alu_*` outputs hold the last driven operands in IDLE and RESP; they do not return to 0.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0, `busy`=0;
  - all `alu_*` = 0;
  - `rsp_result`=0, `rsp_carry`=0, `rsp_opcode`=0, `rsp_err`=0;
  - FIFO empty, FSM in IDLE.
- Latency: a command accepted at edge E into an empty, idle block gives `rsp_valid`=1 after edge E+2.
- Throughput: one response per 2 cycles while `rsp_ready` is held high.
- Capacity: with `rsp_ready`=0, DEPTH+1 commands are accepted (one in RESP, DEPTH queued) before `cmd_ready` drops.
- Reset asserted mid-operation: the in-flight command and all queued commands are discarded, and every output returns to its reset value immediately.

## Configuration
- `ALU_ISSUE_OPCHECK_EN` defined:
  - a popped opcode greater than 9 (outside the ALU map) skips DRIVE and goes directly to RESP;
  - the response is `rsp_err`=1, `rsp_result`=0, `rsp_carry`=0, `rsp_opcode`=the popped opcode;
  - the `alu_*` outputs are not updated.
- `ALU_ISSUE_OPCHECK_EN` undefined:
  - every opcode is forwarded to the ALU;
  - `rsp_err` is constant 0.

## Structure
- Package `alu_issue_pkg`:
  - ALU opcode constants ROL=0, ROR=1, MAX=2, MIN=3, SUB=4, SEQ=5, SRA=6, OR=7, SNE=8, SLL=9;
  - `OP_LAST`=9;
  - FSM state typedef.
- Sub-module `alu_issue_fifo`: parameterised synchronous FIFO (WIDTH×2+4+SHW bits wide, DEPTH entries) with full/empty outputs.

## Test plan
- SUB, a=0x0005, b=0x0003, ALU model attached, `rsp_ready`=1 → `rsp_valid` 2 cycles after accept; `rsp_result`=0x0002, `rsp_opcode`=4.
- MAX, a=0x8000, b=0x7FFF, then ROL, a=0x8001, shift=1, back-to-back with `rsp_ready`=1 → responses 0x8000 then 0x0003, spaced exactly 2 cycles.
- `rsp_ready`=0 with `cmd_valid` held → 5 commands accepted, then `cmd_ready`=0. Release `rsp_ready` → 5 responses in order, and `cmd_ready` returns after the first pop.
- Response held with `rsp_ready`=0 for 10 cycles → `rsp_result`/`rsp_carry`/`rsp_opcode` stable every cycle.
- Reset pulse while in DRIVE with 3 queued commands → all outputs at reset values; no response emitted after release.
- Opcode 4'd12 → with `ALU_ISSUE_OPCHECK_EN`: `rsp_err`=1, `rsp_result`=0x0000, `alu_opcode` unchanged. Without it: `alu_opcode`=12, `rsp_err`=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue controller.
// Opcode map mirrors the attached 16-bit function-style ALU.
package alu_issue_pkg;

    localparam logic [3:0] ROL     = 4'd0;
    localparam logic [3:0] ROR     = 4'd1;
    localparam logic [3:0] MAX     = 4'd2;
    localparam logic [3:0] MIN     = 4'd3;
    localparam logic [3:0] SUB     = 4'd4;
    localparam logic [3:0] SEQ     = 4'd5;
    localparam logic [3:0] SRA     = 4'd6;
    localparam logic [3:0] OR      = 4'd7;
    localparam logic [3:0] SNE     = 4'd8;
    localparam logic [3:0] SLL     = 4'd9;
    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Command FIFO for alu_issue_ctrl; DEPTH must be a power of two >= 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_issue_fifo #(
    parameter int DW    = 41,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller around a combinational ALU: FIFO -> operand regs -> response regs.
// Optional ALU_ISSUE_OPCHECK_EN rejects opcodes beyond OP_LAST with rsp_err instead of driving the ALU.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shift,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [3:0]       rsp_opcode,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CW = 2*WIDTH + 4 + SHW;

    state_t           r_state, w_next;
    logic [CW-1:0]    w_head;
    logic             w_full, w_empty, w_pop, w_head_bad;
    logic [3:0]       w_head_op;
    logic [WIDTH-1:0] w_head_a, w_head_b;
    logic [SHW-1:0]   w_head_sh;

    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a, r_alu_b;
    logic [SHW-1:0]   r_alu_sh;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_carry;
    logic [3:0]       r_rsp_op;

    alu_issue_fifo #(.DW(CW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_data  ({cmd_opcode, cmd_a, cmd_b, cmd_shift}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_op, w_head_a, w_head_b, w_head_sh} = w_head;

`ifdef ALU_ISSUE_OPCHECK_EN
    logic r_rsp_err;
    assign w_head_bad = !op_legal(w_head_op);
    assign rsp_err    = r_rsp_err;
`else
    assign w_head_bad = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // A popped illegal opcode bypasses DRIVE and answers directly from RESP.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = w_head_bad ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE: w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = w_head_bad ? ST_RESP : ST_DRIVE;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sh     <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_op     <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop && !w_head_bad) begin
                r_alu_op <= w_head_op;
                r_alu_a  <= w_head_a;
                r_alu_b  <= w_head_b;
                r_alu_sh <= w_head_sh;
            end
            if (r_state == ST_DRIVE) begin
                r_rsp_result <= alu_result;
                r_rsp_carry  <= alu_carry;
                r_rsp_op     <= r_alu_op;
            end else if (w_pop && w_head_bad) begin
                r_rsp_result <= '0;
                r_rsp_carry  <= 1'b0;
                r_rsp_op     <= w_head_op;
            end
        end
    end

`ifdef ALU_ISSUE_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_rsp_err <= 1'b0;
        else if (r_state == ST_DRIVE)  r_rsp_err <= 1'b0;
        else if (w_pop && w_head_bad)  r_rsp_err <= 1'b1;
    end
`endif

    assign cmd_ready  = !w_full;
    assign rsp_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign alu_opcode = r_alu_op;
    assign alu_input1 = r_alu_a;
    assign alu_input2 = r_alu_b;
    assign alu_shift  = r_alu_sh;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_opcode = r_rsp_op;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached to the alu_* port.
// Honours ALU_ISSUE_OPCHECK_EN for the illegal-opcode case.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_a, cmd_b;
    logic [4:0]  cmd_shift;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1, alu_input2;
    logic [4:0]  alu_shift;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic [3:0]  rsp_opcode;
    logic        rsp_err, busy;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU; carry is the borrow of SUB, otherwise 0.
    logic [31:0] w_rot;
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        w_rot      = '0;
        case (alu_opcode)
            4'd0: begin w_rot = {alu_input1, alu_input1} << alu_shift[3:0]; alu_result = w_rot[31:16]; end
            4'd1: begin w_rot = {alu_input1, alu_input1} >> alu_shift[3:0]; alu_result = w_rot[15:0]; end
            4'd2: alu_result = (alu_input1 > alu_input2) ? alu_input1 : alu_input2;
            4'd3: alu_result = (alu_input1 < alu_input2) ? alu_input1 : alu_input2;
            4'd4: begin alu_result = alu_input1 - alu_input2; alu_carry = alu_input1 < alu_input2; end
            4'd5: alu_result = {15'd0, alu_input1 == alu_input2};
            4'd6: alu_result = $unsigned($signed(alu_input1) >>> alu_shift);
            4'd7: alu_result = alu_input1 | alu_input2;
            4'd8: alu_result = {15'd0, alu_input1 != alu_input2};
            4'd9: alu_result = alu_input1 << alu_shift;
            default: alu_result = alu_input1 ^ alu_input2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] sh);
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] sh);
        chk("push_ready", cmd_ready, 1);
        set_cmd(op, a, b, sh);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        chk("wait_rsp", rsp_valid, 1);
    endtask

    // rsp_ready must be 0; offers OR commands a=n, b=0x100 until the block stops accepting.
    task automatic fill(output int n);
        logic acc;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            set_cmd(4'd7, 16'(n), 16'h0100, 5'd0);
            cmd_valid = 1'b1;
            acc = cmd_ready;
            step();
            if (acc) n++;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n, got;
        int idx [2];
        logic [15:0] res [2];

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        set_cmd(4'd0, 16'd0, 16'd0, 5'd0);
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu", {alu_opcode, alu_input1, alu_input2, alu_shift}, 0);
        chk("rst_rsp", {rsp_result, rsp_carry, rsp_opcode, rsp_err}, 0);
        rst_n = 1'b1;
        step();

        // SUB latency: valid two edges after accept
        rsp_ready = 1'b1;
        push(4'd4, 16'h0005, 16'h0003, 5'd0);
        chk("sub_e0_valid", rsp_valid, 0);
        chk("sub_e0_busy", busy, 1);
        step();
        chk("sub_drive_op", alu_opcode, 4);
        chk("sub_drive_ab", {alu_input1, alu_input2}, 32'h0005_0003);
        chk("sub_drive_valid", rsp_valid, 0);
        step();
        chk("sub_valid", rsp_valid, 1);
        chk("sub_result", rsp_result, 16'h0002);
        chk("sub_opcode", rsp_opcode, 4);
        chk("sub_carry", rsp_carry, 0);
        step();
        chk("sub_done_valid", rsp_valid, 0);
        chk("sub_done_busy", busy, 0);
        chk("alu_hold_op", alu_opcode, 4);

        // held response stays stable; SUB 3-5 borrows
        rsp_ready = 1'b0;
        push(4'd4, 16'h0003, 16'h0005, 5'd0);
        wait_rsp();
        for (int k = 0; k < 10; k++) begin
            chk("hold_result", rsp_result, 16'hFFFE);
            chk("hold_carry", rsp_carry, 1);
            chk("hold_op", rsp_opcode, 4);
            chk("hold_valid", rsp_valid, 1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("hold_release", rsp_valid, 0);

        // back-to-back MAX then ROL
        set_cmd(4'd2, 16'h8000, 16'h7FFF, 5'd0);
        cmd_valid = 1'b1;
        step();
        set_cmd(4'd0, 16'h8001, 16'h0000, 5'd1);
        step();
        cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (rsp_valid) begin
                if (got < 2) begin idx[got] = k; res[got] = rsp_result; end
                got++;
            end
        end
        chk("b2b_count", got, 2);
        chk("b2b_first", res[0], 16'h8000);
        chk("b2b_second", res[1], 16'h0003);
        chk("b2b_spacing", idx[1] - idx[0], 2);

        // capacity: DEPTH+1 accepted with rsp_ready low
        rsp_ready = 1'b0;
        fill(n);
        chk("cap_count", n, 5);
        chk("cap_full_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid) begin
                if (got < 5) chk("cap_order", rsp_result, 32'h0100 | got);
                got++;
            end
            step();
            if (k == 0) chk("cap_ready_back", cmd_ready, 1);
        end
        chk("cap_rsp_count", got, 5);

        // reset during DRIVE with three commands queued
        rsp_ready = 1'b0;
        fill(n);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_in_drive", rsp_valid, 0);
        chk("rd_drive_a", alu_input1, 16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("rd_cmd_ready", cmd_ready, 1);
        chk("rd_rsp_valid", rsp_valid, 0);
        chk("rd_busy", busy, 0);
        chk("rd_alu", {alu_opcode, alu_input1, alu_input2, alu_shift}, 0);
        chk("rd_rsp", {rsp_result, rsp_carry, rsp_opcode, rsp_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rsp_valid) got++;
        end
        chk("rd_no_rsp", got, 0);
        chk("rd_idle_busy", busy, 0);

        // illegal opcode, preceded by a legal SNE
        push(4'd8, 16'h0001, 16'h0002, 5'd0);
        wait_rsp();
        chk("sne_result", rsp_result, 16'h0001);
        step();
        push(4'd12, 16'h1234, 16'h00FF, 5'd0);
        wait_rsp();
        chk("ill_opcode", rsp_opcode, 12);
`ifdef ALU_ISSUE_OPCHECK_EN
        chk("ill_err", rsp_err, 1);
        chk("ill_result", rsp_result, 16'h0000);
        chk("ill_alu_op", alu_opcode, 8);
`else
        chk("ill_err", rsp_err, 0);
        chk("ill_result", rsp_result, 16'h12CB);
        chk("ill_alu_op", alu_opcode, 12);
`endif
        step();
        chk("ill_done", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
